// File: rtl/ram_access_arbiter.sv
// Two-port req/ack front end that sequences the 1024x10 RAM strobes (address load, then write/read).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build is fixed priority (port 0 wins).
module ram_access_arbiter #(
  parameter int AW = 10,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_EN_AddressRegRead,
  output logic          ram_EN_write_to_RAM,
  output logic          ram_EN_read_from_RAM,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, LOAD_ADDR, ACCESS, RESPOND} state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            win;

`ifdef ARB_ROUND_ROBIN_EN
  logic            last_grant_q, last_grant_d;

  always_comb begin
    if (req0 && req1) win = ~last_grant_q;
    else              win = ~req0;
  end
`else
  always_comb begin
    win = ~req0;
  end
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = LOAD_ADDR;
          gnt_d   = win;
          we_d    = win ? we1    : we0;
          addr_d  = win ? addr1  : addr0;
          wdata_d = win ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = win;
`endif
        end
      end
      LOAD_ADDR: state_d = ACCESS;
      ACCESS: begin
        state_d = RESPOND;
        if (!we_q) begin
          if (gnt_q) rdata1_d = ram_data_out;
          else       rdata0_d = ram_data_out;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears every flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // NOTE: strobes and acks are gated by ~reset so a reset cycle never touches the RAM or a requester.
  always_comb begin
    ram_address           = '0;
    ram_data_in           = '0;
    ram_EN_AddressRegRead = 1'b0;
    ram_EN_write_to_RAM   = 1'b0;
    ram_EN_read_from_RAM  = 1'b0;
    ack0                  = 1'b0;
    ack1                  = 1'b0;
    busy                  = (state_q != IDLE);
    unique case (state_q)
      LOAD_ADDR: begin
        ram_address           = addr_q;
        ram_EN_AddressRegRead = ~reset;
      end
      ACCESS: begin
        ram_address = addr_q;
        if (we_q) begin
          ram_data_in         = wdata_q;
          ram_EN_write_to_RAM = ~reset;
        end else begin
          ram_EN_read_from_RAM = ~reset;
        end
      end
      RESPOND: begin
        ack0 = ~gnt_q & ~reset;
        ack1 =  gnt_q & ~reset;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level model of the arbiter and RAM.
module tb_ram_access_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [9:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, busy;
  logic [9:0] rdata0, rdata1;
  logic [9:0] ram_address, ram_data_in, ram_data_out;
  logic       ram_EN_AddressRegRead, ram_EN_write_to_RAM, ram_EN_read_from_RAM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(.AW(10), .DW(10)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_EN_AddressRegRead(ram_EN_AddressRegRead),
    .ram_EN_write_to_RAM(ram_EN_write_to_RAM),
    .ram_EN_read_from_RAM(ram_EN_read_from_RAM),
    .ram_data_out(ram_data_out)
  );

  // RAM device: address register and writes sampled on negedge, read drive is combinational.
  logic [9:0] ram_mem [1024];
  logic [9:0] ram_areg = '0;
  bit         ram_inited = 1'b0;
  always @(negedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
      ram_inited <= 1'b1;
    end else begin
      if (ram_EN_AddressRegRead) ram_areg <= ram_address;
      if (ram_EN_write_to_RAM)   ram_mem[ram_areg] <= ram_data_in;
    end
  end
  assign ram_data_out = ram_EN_read_from_RAM ? ram_mem[ram_areg] : '0;

  int wr_count = 0;
  int onehot_viol = 0;
  int act_log[$];
  always @(negedge clk) begin
    if (ram_EN_write_to_RAM) wr_count++;
    if ($countones({ram_EN_AddressRegRead, ram_EN_write_to_RAM, ram_EN_read_from_RAM}) > 1)
      onehot_viol++;
    if (ack0) act_log.push_back(0);
    if (ack1) act_log.push_back(1);
  end

  // Reference model state
  logic [9:0] ref_mem [1024];
  logic [9:0] exp_rdata [2];
  int         m_last;
  bit         cur_we [2];
  logic [9:0] cur_addr [2];
  logic [9:0] cur_wdata [2];
  bit         rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_txn(input int p, input bit w, input logic [9:0] a, input logic [9:0] d);
    cur_we[p] = w; cur_addr[p] = a; cur_wdata[p] = d;
  endtask

  task automatic rand_txn(input int p);
    int r;
    logic [9:0] a;
    r = int'($urandom_range(0, 7));
    if (r == 0)      a = 10'h000;
    else if (r == 1) a = 10'h3FF;
    else if (r <= 5) a = 10'($urandom_range(0, 15));
    else             a = 10'($urandom_range(0, 1023));
    set_txn(p, 1'($urandom_range(0, 1)), a, 10'($urandom_range(0, 1023)));
  endtask

  task automatic drive_port(input int p, input bit perturb);
    if (p == 0) begin
      we0    = perturb ? ~cur_we[0]    : cur_we[0];
      addr0  = perturb ? cur_addr[0] ^ 10'h001 : cur_addr[0];
      wdata0 = perturb ? ~cur_wdata[0] : cur_wdata[0];
    end else begin
      we1    = perturb ? ~cur_we[1]    : cur_we[1];
      addr1  = perturb ? cur_addr[1] ^ 10'h001 : cur_addr[1];
      wdata1 = perturb ? ~cur_wdata[1] : cur_wdata[1];
    end
  endtask

  // Called at a drive point (posedge+1) with the DUT idle; port p makes n_p back-to-back requests.
  task automatic transact(input int n0, input int n1, input bit perturb);
    int left [2];
    int win;
    bit e_we;
    logic [9:0] e_addr, e_wdata;
    left[0] = n0; left[1] = n1;
    drive_port(0, 1'b0); drive_port(1, 1'b0);
    req0 = (n0 > 0); req1 = (n1 > 0);
    while (left[0] > 0 || left[1] > 0) begin
      if (left[0] > 0 && left[1] > 0) win = (RR && m_last == 0) ? 1 : 0;
      else                            win = (left[0] > 0) ? 0 : 1;
      e_we = cur_we[win]; e_addr = cur_addr[win]; e_wdata = cur_wdata[win];
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_acks", 32'({ack1, ack0}), 0);
      @(posedge clk); #1;
      if (perturb) drive_port(win, 1'b1);
      @(negedge clk);
      check("load_busy", 32'(busy), 1);
      check("load_strobes", 32'({ram_EN_AddressRegRead, ram_EN_write_to_RAM, ram_EN_read_from_RAM}), 32'b100);
      check("load_addr", 32'(ram_address), 32'(e_addr));
      @(posedge clk); #1;
      @(negedge clk);
      check("access_strobes", 32'({ram_EN_AddressRegRead, ram_EN_write_to_RAM, ram_EN_read_from_RAM}),
            e_we ? 32'b010 : 32'b001);
      check("access_addr", 32'(ram_address), 32'(e_addr));
      if (e_we) check("access_wdata", 32'(ram_data_in), 32'(e_wdata));
      @(posedge clk); #1;
      if (e_we) ref_mem[e_addr] = e_wdata;
      else      exp_rdata[win] = ref_mem[e_addr];
      @(negedge clk);
      check("resp_ack0", 32'(ack0), 32'(win == 0));
      check("resp_ack1", 32'(ack1), 32'(win == 1));
      check("resp_strobes", 32'({ram_EN_AddressRegRead, ram_EN_write_to_RAM, ram_EN_read_from_RAM}), 0);
      check("resp_ram_addr", 32'(ram_address), 0);
      check("rdata0", 32'(rdata0), 32'(exp_rdata[0]));
      check("rdata1", 32'(rdata1), 32'(exp_rdata[1]));
      m_last = win;
      @(posedge clk); #1;
      left[win]--;
      if (left[win] == 0) begin
        if (win == 0) req0 = 1'b0; else req1 = 1'b0;
      end else if (rand_mode) begin
        rand_txn(win);
      end
      drive_port(win, 1'b0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 32'({ram_EN_AddressRegRead, ram_EN_write_to_RAM, ram_EN_read_from_RAM}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_acks", 32'({ack1, ack0}), 0);
    check("rst_rdata0", 32'(rdata0), 0);
    check("rst_rdata1", 32'(rdata1), 0);
    check("rst_ram_addr", 32'(ram_address), 0);
    check("rst_ram_din", 32'(ram_data_in), 0);
    @(posedge clk); #1;
    m_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  initial begin
    int n0, n1, base, wr_before;
    int exp_order [4];
    if (RR) exp_order = '{0, 1, 0, 1};
    else    exp_order = '{0, 0, 0, 0};
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    apply_reset();

    // Write then read back on port 0
    set_txn(0, 1'b1, 10'h005, 10'h2AA); transact(1, 0, 1'b0);
    set_txn(0, 1'b0, 10'h005, 10'h000); transact(1, 0, 1'b0);
    check("t1_rdata0", 32'(rdata0), 32'h2AA);

    // Top address written by port 1, read by port 0
    set_txn(1, 1'b1, 10'h3FF, 10'h155); transact(0, 1, 1'b0);
    set_txn(0, 1'b0, 10'h3FF, 10'h000); transact(1, 0, 1'b0);
    check("t2_rdata0", 32'(rdata0), 32'h155);

    // Simultaneous requests straight after reset
    apply_reset();
    set_txn(0, 1'b0, 10'h001, 10'h000); set_txn(1, 1'b0, 10'h002, 10'h000);
    transact(1, 1, 1'b0);

    // Saturated requests on both ports
    base = act_log.size();
    set_txn(0, 1'b1, 10'h100, 10'h011); set_txn(1, 1'b1, 10'h200, 10'h022);
    transact(4, 4, 1'b0);
    check("t4_ack_count", 32'(act_log.size() - base), 8);
    for (int i = 0; i < 4; i++) check($sformatf("t4_grant%0d", i), 32'(act_log[base + i]), 32'(exp_order[i]));

    // Reset during ACCESS aborts a write
    set_txn(0, 1'b1, 10'h010, 10'h0AA); transact(1, 0, 1'b0);
    wr_before = wr_count;
    set_txn(0, 1'b1, 10'h010, 10'h0FF); drive_port(0, 1'b0); req0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_wr_gated", 32'(ram_EN_write_to_RAM), 0);
    check("t5_ack0_rst", 32'(ack0), 0);
    @(posedge clk); #1;
    req0 = 1'b0; reset = 1'b0;
    m_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_ack", 32'({ack1, ack0}), 0);
      check("t5_idle", 32'(busy), 0);
    end
    @(posedge clk); #1;
    check("t5_no_write", 32'(wr_count), 32'(wr_before));
    check("t5_rdata0_cleared", 32'(rdata0), 0);
    set_txn(0, 1'b0, 10'h010, 10'h000); transact(1, 0, 1'b0);
    check("t5_rdata0", 32'(rdata0), 32'h0AA);

    // Inputs changed after grant must be ignored
    set_txn(0, 1'b1, 10'h020, 10'h123); transact(1, 0, 1'b0);
    set_txn(0, 1'b0, 10'h020, 10'h000); transact(1, 0, 1'b1);
    check("t6_rdata0", 32'(rdata0), 32'h123);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      n0 = int'($urandom_range(0, 2));
      n1 = int'($urandom_range(0, 2));
      if (n0 + n1 == 0) n0 = 1;
      rand_txn(0); rand_txn(1);
      transact(n0, n1, 1'($urandom_range(0, 1)));
    end

    check("onehot_strobes", 32'(onehot_viol), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "simulation timeout");
  end

endmodule
